mul_digit_serial: RTL and testbench

- Digit-serial integer multiplier. It forms the 2*Q_LEN-bit product C = A*B that feeds mod_red_mixed_ll directly downstream.
- The modulus q is carried alongside, so the reduction stage receives C and q aligned on the same cycle.
- B is consumed D_LEN bits per cycle using a Q_LEN x D_LEN partial-product multiplier. This trades latency for DSP count.
- Handshake: valid/ready on input; valid-only pulse on output, since the downstream reduction is a fixed-latency pipeline with no backpressure.

---
 rtl/mul_digit_serial.sv | 122 ++++++++++++
 tb/tb_mul_digit_serial.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_digit_serial.sv
// Digit-serial integer multiplier: C = A*B, with B consumed D_LEN bits per cycle.
// The modulus q_in rides alongside so C and q leave on the same cycle.
module mul_digit_serial #(
  parameter int Q_LEN  = 60,
  parameter int K      = 2*Q_LEN,
  parameter int D_LEN  = 15,
  parameter int FF_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q_LEN-1:0] A,
  input  logic [Q_LEN-1:0] B,
  input  logic [Q_LEN-1:0] q_in,
  output logic             out_valid,
  output logic [K-1:0]     C,
  output logic [Q_LEN-1:0] q
);

  localparam int NUM_D = (Q_LEN + D_LEN - 1) / D_LEN;
  localparam int B_W   = NUM_D * D_LEN;
  localparam int CNT_W = (NUM_D > 1) ? $clog2(NUM_D) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_D - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [Q_LEN-1:0]         a_r;
  logic [Q_LEN-1:0]         q_r;
  logic [B_W-1:0]           b_r;
  logic [K-1:0]             acc;
  logic                     done;
  logic [D_LEN-1:0]         digit;
  logic [Q_LEN+D_LEN-1:0]   pp;
  logic [K-1:0]             pp_sh;
  logic                     accept;

  assign accept = in_valid & in_ready;

  always_comb begin
    digit = b_r[cnt*D_LEN +: D_LEN];
    pp    = a_r * digit;
    pp_sh = K'(pp) << (cnt*D_LEN);
  end

  // Accept / digit-accumulate FSM; done marks the edge that added the last digit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      cnt      <= '0;
      a_r      <= '0;
      q_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_r      <= A;
            q_r      <= q_in;
            b_r      <= B_W'(B);
            cnt      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc + pp_sh;
          if (cnt == LAST) begin
            cnt      <= '0;
            in_ready <= 1'b1;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (FF_OUT != 0) begin : g_ff_out
      logic [K-1:0]     c_r;
      logic [Q_LEN-1:0] q_o;
      logic             vld_r;

      // Output stage: loads one edge after the final digit, independent of a new accept
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          c_r   <= '0;
          q_o   <= '0;
          vld_r <= 1'b0;
        end else begin
          vld_r <= done;
          if (done) begin
            c_r <= acc;
            q_o <= q_r;
          end
        end
      end

      assign C         = c_r;
      assign q         = q_o;
      assign out_valid = vld_r;
    end else begin : g_acc_out
      assign C         = acc;
      assign q         = q_r;
      assign out_valid = done;
    end
  endgenerate

endmodule

// File: tb/tb_mul_digit_serial.sv
// Bench for mul_digit_serial: directed and random products against plain A*B,
// on three parameterisations (D_LEN/FF_OUT = 15/1, 16/0, 60/1).
module tb_mul_digit_serial;

  localparam int Q = 60;
  localparam int K = 120;
  localparam int LAT[3]  = '{5, 4, 2};
  localparam int NUMD[3] = '{4, 4, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid [3];
  logic         in_ready [3];
  logic [Q-1:0] A  [3];
  logic [Q-1:0] B  [3];
  logic [Q-1:0] qi [3];
  logic [Q-1:0] qo [3];
  logic         out_valid [3];
  logic [K-1:0] C  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_digit_serial #(.Q_LEN(Q), .K(K), .D_LEN(15), .FF_OUT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(A[0]), .B(B[0]), .q_in(qi[0]), .out_valid(out_valid[0]), .C(C[0]), .q(qo[0]));
  mul_digit_serial #(.Q_LEN(Q), .K(K), .D_LEN(16), .FF_OUT(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(A[1]), .B(B[1]), .q_in(qi[1]), .out_valid(out_valid[1]), .C(C[1]), .q(qo[1]));
  mul_digit_serial #(.Q_LEN(Q), .K(K), .D_LEN(60), .FF_OUT(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .A(A[2]), .B(B[2]), .q_in(qi[2]), .out_valid(out_valid[2]), .C(C[2]), .q(qo[2]));

  function automatic logic [K-1:0] ref_mul(input logic [Q-1:0] a, input logic [Q-1:0] b);
    return K'(a) * K'(b);
  endfunction

  function automatic logic [Q-1:0] rnd_val();
    logic [63:0] r;
    int mode;
    mode = int'($urandom_range(0, 5));
    r = {$urandom(), $urandom()};
    if (mode == 0) return '0;
    if (mode == 1) return '1;
    if (mode == 2) return Q'(r[15:0]);
    return r[Q-1:0];
  endfunction

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int u, input logic [Q-1:0] a, input logic [Q-1:0] b,
                        input logic [Q-1:0] qq, input string tag);
    int lat;
    logic [K-1:0] exp_c;
    exp_c = ref_mul(a, b);
    for (int i = 0; i < 20 && !in_ready[u]; i++) tick();
    chk({tag, ".ready"}, K'(in_ready[u]), K'(1));
    A[u] = a; B[u] = b; qi[u] = qq; in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    A[u] = rnd_val(); B[u] = rnd_val(); qi[u] = rnd_val();
    lat = 0;
    while (!out_valid[u] && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, K'(lat), K'(LAT[u]));
    chk({tag, ".C"}, C[u], exp_c);
    chk({tag, ".q"}, K'(qo[u]), K'(qq));
    tick();
    chk({tag, ".pulse"}, K'(out_valid[u]), K'(0));
    chk({tag, ".hold"}, C[u], exp_c);
  endtask

  initial begin
    logic [K-1:0] eq_c[$];
    logic [Q-1:0] eq_q[$];
    int           eq_t[$];
    int           low;
    int           n_acc;
    logic         prev_acc;
    logic         prev_ov;
    logic [Q-1:0] a, b, qq;

    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0; A[u] = '0; B[u] = '0; qi[u] = '0;
    end

    // Reset state
    tick(); tick();
    chk("rst.in_ready", K'(in_ready[0]), K'(0));
    chk("rst.out_valid", K'(out_valid[0]), K'(0));
    chk("rst.C", C[0], '0);
    chk("rst.q", K'(qo[0]), '0);
    chk("rst.C_ff0", C[1], '0);
    rst = 1'b1;
    tick();

    // Directed products
    run_op(0, 60'h123456789ABCDEF, 60'd2, 60'h882d43400000001, "t1");
    chk("t1.const", C[0], 120'h2468ACF13579BDE);
    tick(); tick();
    chk("t1.hold_C", C[0], 120'h2468ACF13579BDE);
    chk("t1.hold_q", K'(qo[0]), K'(60'h882d43400000001));
    run_op(0, 60'hFFFFFFFFFFFFFFF, 60'hFFFFFFFFFFFFFFF, 60'd7, "t2");
    chk("t2.const", C[0], 120'hFFFFFFFFFFFFFFE000000000000001);
    run_op(0, 60'd0, rnd_val() | 60'd1, 60'd3, "t3a");
    chk("t3a.const", C[0], '0);
    run_op(0, 60'd1, 60'h882d43400000000, 60'd5, "t3b");
    chk("t3b.const", C[0], 120'h882d43400000000);

    // in_valid held high with changing operands
    low = 0; n_acc = 0; prev_acc = 1'b0; prev_ov = 1'b0;
    in_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (prev_acc) low = NUMD[0];
      chk("t4.in_ready", K'(in_ready[0]), K'(low == 0));
      if (low > 0) low--;
      chk("t4.no_double", K'(out_valid[0] & prev_ov), K'(0));
      prev_ov = out_valid[0];
      if (out_valid[0]) begin
        chk("t4.queued", K'(eq_c.size() > 0), K'(1));
        if (eq_c.size() > 0) begin
          chk("t4.C", C[0], eq_c.pop_front());
          chk("t4.q", K'(qo[0]), K'(eq_q.pop_front()));
          chk("t4.latency", K'(cyc - eq_t.pop_front()), K'(LAT[0]));
        end
      end
      a = rnd_val(); b = rnd_val(); qq = rnd_val();
      A[0] = a; B[0] = b; qi[0] = qq;
      prev_acc = in_ready[0];
      if (in_ready[0]) begin
        eq_c.push_back(ref_mul(a, b));
        eq_q.push_back(qq);
        eq_t.push_back(cyc + 1);
        n_acc++;
      end
      tick();
    end
    in_valid[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid[0] && eq_c.size() > 0) begin
        chk("t4.drain_C", C[0], eq_c.pop_front());
        chk("t4.drain_q", K'(qo[0]), K'(eq_q.pop_front()));
        void'(eq_t.pop_front());
      end
      tick();
    end
    chk("t4.all_out", K'(eq_c.size()), K'(0));
    chk("t4.accepts", K'(n_acc), K'(10));

    // Reset two cycles after an accept
    A[0] = 60'hABCDEF; B[0] = 60'h12345; qi[0] = 60'd9; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("t5.async_C", C[0], '0);
    chk("t5.async_q", K'(qo[0]), '0);
    chk("t5.async_ready", K'(in_ready[0]), K'(0));
    chk("t5.async_valid", K'(out_valid[0]), K'(0));
    tick(); tick();
    chk("t5.held_ready", K'(in_ready[0]), K'(0));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5.no_valid", K'(out_valid[0]), K'(0));
    end
    run_op(0, 60'hABCDEF, 60'h12345, 60'd9, "t5.next");

    // Random sweep over the three parameterisations
    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 150; n++) begin
        run_op(u, rnd_val(), rnd_val(), rnd_val(), $sformatf("t6.u%0d", u));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
